// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Four-digit multiplexed seven-segment scanner with a double-buffered value.
// A write lands in a pending register. The pending register is copied into
// the shown register only at a frame boundary, so one frame never mixes
// digits from two different writes.
// Every output is a register loaded from a decode of the scan state, so no
// input reaches an output combinationally.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_ctrl #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    output logic [3:0]  an,
    output logic [0:6]  disp,
    output logic        frame_done
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pending_q, pending_d;
    logic [15:0]   shown_q, shown_d;
    logic [3:0]    an_q, an_d;
    logic [0:6]    disp_q, disp_d;
    logic          fd_q, fd_d;

    logic          slotEnd;
    logic          frameEdge;
    logic [3:0]    curDigit;
    logic          leadBlank;
    logic [0:6]    segCode;

    // Next scan position and buffer contents. A write that arrives on the
    // frame edge bypasses pending and goes straight into the shown register.
    always_comb begin
        slotEnd   = (cnt_q == CW'(CLK_DIV - 1));
        frameEdge = slotEnd && (idx_q == 2'd3);
        cnt_d     = slotEnd ? '0 : cnt_q + CW'(1);
        idx_d     = slotEnd ? idx_q + 2'd1 : idx_q;
        pending_d = load ? value : pending_q;
        shown_d   = shown_q;
        if (frameEdge) begin
            shown_d = load ? value : pending_q;
        end
    end

    // Select the digit in the current slot and work out whether it is a
    // leading zero. Only the shown register is used for this, never pending.
    always_comb begin
        curDigit  = shown_q[{idx_q, 2'b00} +: 4];
        leadBlank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    leadBlank = (shown_q[15:12] == 4'h0);
            2'd2:    leadBlank = (shown_q[15:8]  == 12'h000);
            2'd1:    leadBlank = (shown_q[15:4]  == 12'h000);
            default: leadBlank = 1'b0;
        endcase
`endif
    end

    // Active-low segment pattern, written as a..g from left to right.
    // Codes above 9 produce a blank digit.
    always_comb begin
        case (curDigit)
            4'd0:    segCode = 7'b0000001;
            4'd1:    segCode = 7'b1001111;
            4'd2:    segCode = 7'b0010010;
            4'd3:    segCode = 7'b0000110;
            4'd4:    segCode = 7'b1001100;
            4'd5:    segCode = 7'b0100100;
            4'd6:    segCode = 7'b0100000;
            4'd7:    segCode = 7'b0001111;
            4'd8:    segCode = 7'b0000000;
            4'd9:    segCode = 7'b0000100;
            default: segCode = 7'b1111111;
        endcase
    end

    // Output decode from the present registered state. The first cycle of
    // each slot is the blank phase, which stops ghosting between digits.
    always_comb begin
        an_d   = 4'b1111;
        disp_d = 7'b1111111;
        fd_d   = (cnt_q == '0) && (idx_q == 2'd0);
        if (cnt_q != '0) begin
            an_d = ~(4'b0001 << idx_q);
            if (!leadBlank) begin
                disp_d = segCode;
            end
        end
    end

    // State and output registers. Reset wins over a write and discards both
    // buffers and the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pending_q <= 16'h0000;
            shown_q   <= 16'h0000;
            an_q      <= 4'b1111;
            disp_q    <= 7'b1111111;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            an_q      <= an_d;
            disp_q    <= disp_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign disp       = disp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with CLK_DIV=4.
// A frame-position model predicts the outputs and is compared every cycle.
// Literal checks at chosen scan positions pin the model.
// Define LEADING_ZERO_BLANK_EN for both files to exercise blanking.
module tb_display_scan_ctrl;

    localparam int D     = 4;
    localparam int FRAME = 4 * D;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  an;
    logic [0:6]  disp;
    logic        frame_done;

    int total;
    int bad;

    // Model state: position within the frame, and the two buffers.
    int          mpos;
    logic [15:0] mPend;
    logic [15:0] mShown;
    logic [3:0]  expAn;
    logic [6:0]  expDisp;
    logic        expFd;
    logic        modelValid;

    display_scan_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .load(load),
        .an(an),
        .disp(disp),
        .frame_done(frame_done)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] segOf(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Segments expected for digit k of a value. This takes the leading-zero
    // rule into account when blanking is enabled.
    function automatic logic [6:0] digitSeg(input logic [15:0] v, input int k);
        logic [15:0] above;
        above = v >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && above == 16'h0000) return 7'b1111111;
`endif
        return segOf(above[3:0]);
    endfunction

    // Behavioural model. Outputs registered at an edge show the decode of
    // the frame position held before that edge.
    always @(posedge clk) begin
        if (rst) begin
            modelValid = 1'b1;
            mpos    = 0;
            mPend   = 16'h0000;
            mShown  = 16'h0000;
            expAn   = 4'b1111;
            expDisp = 7'b1111111;
            expFd   = 1'b0;
        end else if (modelValid) begin
            expFd = (mpos == 0);
            if (mpos % D == 0) begin
                expAn   = 4'b1111;
                expDisp = 7'b1111111;
            end else begin
                expAn   = ~(4'b0001 << (mpos / D));
                expDisp = digitSeg(mShown, mpos / D);
            end
            mpos = (mpos + 1) % FRAME;
            if (mpos == 0) mShown = load ? value : mPend;
            if (load) mPend = value;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("model_an", {12'h000, an}, {12'h000, expAn});
            checkOutput("model_disp", {9'h000, disp}, {9'h000, expDisp});
            checkOutput("model_fd", {15'h0000, frame_done}, {15'h0000, expFd});
        end
    end

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v);
        rst   = r;
        load  = l;
        value = v;
        @(negedge clk);
    endtask

    // Advance to the negedge at which the model position equals target.
    task automatic waitMpos(input int target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (mpos == target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_pos: got timeout expected position %0d", target);
        end
    endtask

    // Check the outputs in the middle of the SHOW phase of a slot.
    task automatic checkSlot(input int slot, input logic [3:0] eAn, input logic [6:0] eDisp, input string name);
        waitMpos(slot * D + 3);
        checkOutput({name, "_an"}, {12'h000, an}, {12'h000, eAn});
        checkOutput({name, "_disp"}, {9'h000, disp}, {9'h000, eDisp});
    endtask

    logic [3:0] anSeq [6];
    logic [6:0] zeroHi;

    initial begin
        total = 0;
        bad = 0;
        modelValid = 1'b0;
        mpos = 0;
        anSeq[0] = 4'b1111; anSeq[1] = 4'b1110; anSeq[2] = 4'b1110;
        anSeq[3] = 4'b1110; anSeq[4] = 4'b1111; anSeq[5] = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        zeroHi = 7'b1111111;
`else
        zeroHi = 7'b0000001;
`endif
        rst = 1'b1;
        load = 1'b0;
        value = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_an", {12'h000, an}, 16'h000F);
        checkOutput("reset_disp", {9'h000, disp}, 16'h007F);
        checkOutput("reset_fd", {15'h0000, frame_done}, 16'h0000);

        $display("[TB] reset release sequence");
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("rel_fd", {15'h0000, frame_done}, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            checkOutput("rel_an", {12'h000, an}, {12'h000, anSeq[i]});
            @(negedge clk);
        end

        $display("[TB] load mid-frame");
        waitMpos(6);
        applyStimulus(1'b0, 1'b1, 16'h1234);
        load = 1'b0;
        checkSlot(2, 4'b1011, zeroHi, "old_frame");
        checkSlot(0, 4'b1110, 7'b1001100, "f1234_d0");
        checkSlot(1, 4'b1101, 7'b0000110, "f1234_d1");
        checkSlot(2, 4'b1011, 7'b0010010, "f1234_d2");
        checkSlot(3, 4'b0111, 7'b1001111, "f1234_d3");

        $display("[TB] invalid code");
        waitMpos(5);
        applyStimulus(1'b0, 1'b1, 16'h00A9);
        load = 1'b0;
        checkSlot(0, 4'b1110, 7'b0000100, "a9_d0");
        checkSlot(1, 4'b1101, 7'b1111111, "a9_d1");

        $display("[TB] load at frame boundary");
        waitMpos(FRAME - 1);
        applyStimulus(1'b0, 1'b1, 16'h5678);
        load = 1'b0;
        checkSlot(0, 4'b1110, 7'b0000000, "edge_d0");

        $display("[TB] two loads in one frame");
        waitMpos(6);
        applyStimulus(1'b0, 1'b1, 16'h1111);
        load = 1'b0;
        waitMpos(8);
        applyStimulus(1'b0, 1'b1, 16'h9876);
        load = 1'b0;
        checkSlot(2, 4'b1011, 7'b0100000, "hold_d2");
        checkSlot(0, 4'b1110, 7'b0100000, "last_d0");
        checkSlot(3, 4'b0111, 7'b0000100, "last_d3");

        $display("[TB] leading zeros");
        waitMpos(6);
        applyStimulus(1'b0, 1'b1, 16'h0050);
        load = 1'b0;
        checkSlot(0, 4'b1110, 7'b0000001, "lz_d0");
        checkSlot(1, 4'b1101, 7'b0100100, "lz_d1");
        checkSlot(2, 4'b1011, zeroHi, "lz_d2");
        checkSlot(3, 4'b0111, zeroHi, "lz_d3");

        $display("[TB] reset mid-frame");
        waitMpos(2);
        applyStimulus(1'b0, 1'b1, 16'h4321);
        load = 1'b0;
        waitMpos(2 * D + 2);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("mid_rst_an", {12'h000, an}, 16'h000F);
        checkOutput("mid_rst_disp", {9'h000, disp}, 16'h007F);
        checkOutput("mid_rst_fd", {15'h0000, frame_done}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        waitMpos(8);
        checkSlot(0, 4'b1110, 7'b0000001, "clr_d0");
        checkSlot(3, 4'b0111, zeroHi, "clr_d3");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 CLK_DIV, default 50000, meaning clock cycles per digit slot; legal values are 2 and above.
REQ-002 clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  meaning synchronous, active-high reset.
REQ-004 value  input  16  meaning four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-005 load  input  1  meaning a one-cycle strobe that captures value into the pending register.
REQ-006 an  output  4  meaning active-low digit enables; an[k] selects digit k.
REQ-007 disp  output  7 ([0:6])  meaning active-low segments; disp[0]=a through disp[6]=g.
REQ-008 frame_done  output  1  meaning a one-cycle pulse at each frame boundary.

Function
REQ-009 The slot counter cnt SHALL count 0 to CLK_DIV-1 and then wrap to 0.
REQ-010 On each wrap of cnt, the digit index idx SHALL advance in the order 0 -> 1 -> 2 -> 3 -> 0.
REQ-011 Each digit slot SHALL have two phases:
- BLANK: the cycle where cnt==0; an SHALL be 4'b1111.
- SHOW: cycles where cnt is 1 to CLK_DIV-1; only an[idx] SHALL be 0.
REQ-012 disp SHALL carry the encoding of the shown digit in SHOW and 7'b1111111 in BLANK.
REQ-013 Encoding, written disp[0:6]:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- codes 10 to 15 = 1111111 (blank)
REQ-014 an, disp and frame_done SHALL be decoded only from registered state; there SHALL be no combinational path from any input to any output.
REQ-015 Double buffering:
- load SHALL write value into the pending register.
- The pending register SHALL copy into the shown register only at a frame boundary, i.e. the edge where idx goes from 3 to 0 at the cnt wrap.
REQ-016 A frame SHALL never show digits from two different loads.
REQ-017 If load and the frame boundary happen on the same edge, the new value SHALL go straight into the shown register and be used for the frame that starts.
REQ-018 If several loads arrive within one frame, the last one SHALL win.
REQ-019 frame_done SHALL be 1 exactly in the cycle where idx==0 and cnt==0.
REQ-020 Latency from a load to its first shown digit: at most 4*CLK_DIV+1 cycles.

Reset
REQ-021 When rst is 1, the block SHALL set cnt=0, idx=0, pending=16'h0000 and shown=16'h0000.
REQ-022 During reset and in the first cycle after it, the outputs SHALL be:
- an=4'b1111
- disp=7'b1111111
- frame_done=0
REQ-023 After reset is released, scanning SHALL start from idx=0 at cnt=0, with frame_done=1 in the first cycle after release.
REQ-024 rst SHALL take priority over load.
REQ-025 Reset in the middle of a frame SHALL throw away the pending value and the scan position.

Configuration
REQ-026 The macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking:
- Defined: a digit k from 3 down to 1 SHALL show blank if it and every digit above it in the shown value are 0; digit 0 SHALL never be blanked.
- Not defined: every digit SHALL be shown using the REQ-013 encoding.
REQ-027 The blanking decision SHALL be based on the shown register only.

Verification (CLK_DIV=4)
REQ-028 Reset release:
- Stimulus: release rst.
- Response: frame_done=1 in the first cycle; an follows 1111, 1110, 1110, 1110, 1111, 1101, and so on.
REQ-029 Load then scan:
- Stimulus: load value=16'h1234 in the middle of a frame.
- Response: the current frame stays 0000; the next frame shows disp 1001100 on an=1110, 0000110 on 1101, 0010010 on 1011 and 1001111 on 0111.
REQ-030 Invalid code:
- Stimulus: value=16'h00A9.
- Response: digit 1 shows 1111111 and digit 0 shows 0000100.
REQ-031 Load at the boundary:
- Stimulus: load on the edge where idx goes 3 to 0.
- Response: that frame already shows the new value.
- Stimulus: two loads within one frame.
- Response: the second value is shown.
REQ-032 Leading zeros:
- Stimulus: value=16'h0050 with LEADING_ZERO_BLANK_EN defined.
- Response: digits 3 and 2 are 1111111, digit 1 is 0100100, digit 0 is 0000001.
- Without the macro: digits 3 and 2 are 0000001.
REQ-033 Reset mid-frame:
- Stimulus: assert rst while idx=2 and cnt=2.
- Response: outputs go to their reset values on the next edge, and pending clears to 0000.
